// File: rtl/tdc_phase_quantizer.sv
// Time-to-digital phase quantizer for a ring-oscillator DPLL.
// Each enabled FREF edge snapshots the oscillator tap vector and its Gray-coded
// cycle counter. On the following edge the snapshot is turned into an absolute
// phase {binary count, fractional tap position}. The phase advance since the
// last accepted snapshot is also produced. A snapshot with more than one edge
// in the tap vector is a metastability bubble: it is flagged and otherwise
// ignored.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | quantizer off; outputs hold, no strobes
// PRIME | waiting for a first good snapshot to seed the phase reference
// RUN   | every good snapshot updates phase_out/dphase and pulses valid

module tdc_phase_quantizer #(
  parameter  int N_PH   = 32,
  parameter  int CNT_W  = 8,
  localparam int FRAC_W = $clog2(2 * N_PH),
  localparam int PH_W   = CNT_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_PH-1:0]   osc_phases,
  input  logic [CNT_W-1:0]  osc_cnt_gray,
  output logic [PH_W-1:0]   phase_out,
  output logic [PH_W-1:0]   dphase,
  output logic              valid,
  output logic              bubble_err
);

  localparam int RL_W = FRAC_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state;
  logic [N_PH-1:0]    s;
  logic [CNT_W-1:0]   g;
  logic [PH_W-1:0]    prev_ph;

  logic [FRAC_W-1:0]  trans;
  logic [RL_W-1:0]    run_len;
  logic               found;
  logic               bubble;
  logic [CNT_W-1:0]   cnt_bin;
  logic [FRAC_W-1:0]  frac;
  logic [PH_W-1:0]    ph;

  // Stage 1: capture the asynchronous oscillator state while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      g <= '0;
    end else if (en) begin
      s <= osc_phases;
      g <= osc_cnt_gray;
    end
  end

  // Stage 2 decode: bubble detection, run length from tap 0, Gray-to-binary.
  always_comb begin
    trans   = '0;
    run_len = '0;
    found   = 1'b0;
    cnt_bin = '0;
    for (int i = 1; i < N_PH; i++) begin
      if (s[i] != s[i-1]) trans = trans + FRAC_W'(1);
    end
    // No edge at all means the run wraps the whole ring, i.e. position 0.
    for (int i = 1; i < N_PH; i++) begin
      if (!found && (s[i] != s[0])) begin
        run_len = RL_W'(i);
        found   = 1'b1;
      end
    end
    cnt_bin[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      cnt_bin[i] = cnt_bin[i+1] ^ g[i];
    end
  end

  assign bubble = (trans > FRAC_W'(1));
  // A low tap 0 means the wave is in its second half-period: offset by N_PH.
  assign frac   = {~s[0], run_len};
  assign ph     = {cnt_bin, frac};

  // Sequencing FSM with registered outputs; en low always forces IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_ph    <= '0;
      phase_out  <= '0;
      dphase     <= '0;
      valid      <= 1'b0;
      bubble_err <= 1'b0;
    end else begin
      valid      <= 1'b0;
      bubble_err <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= PRIME;
          PRIME: begin
            if (bubble) begin
              bubble_err <= 1'b1;
            end else begin
              prev_ph   <= ph;
              phase_out <= ph;
              state     <= RUN;
            end
          end
          RUN: begin
            if (bubble) begin
              bubble_err <= 1'b1;
            end else begin
              phase_out <= ph;
              dphase    <= ph - prev_ph;
              prev_ph   <= ph;
              valid     <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_phase_quantizer.sv
// Bench for tdc_phase_quantizer at N_PH=32, CNT_W=8.
module tb_tdc_phase_quantizer;

  typedef struct {
    int          id;
    bit          en;
    logic [31:0] ph;
    logic [7:0]  gc;
    bit          chk;
    bit          v;
    bit          b;
    logic [13:0] po;
    logic [13:0] dp;
  } vec_t;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] osc_phases = '0;
  logic [7:0]  osc_cnt_gray = '0;
  logic [13:0] phase_out;
  logic [13:0] dphase;
  logic        valid;
  logic        bubble_err;

  int   n_vec = 0;
  int   n_miss = 0;
  vec_t sb[$];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  tdc_phase_quantizer #(.N_PH(32), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .osc_phases   (osc_phases),
    .osc_cnt_gray (osc_cnt_gray),
    .phase_out    (phase_out),
    .dphase       (dphase),
    .valid        (valid),
    .bubble_err   (bubble_err)
  );

  function automatic vec_t mkv(int id, bit e, logic [31:0] ph, logic [7:0] gc,
                               bit chk, bit v, bit b, logic [13:0] po, logic [13:0] dp);
    vec_t r;
    r.id = id; r.en = e; r.ph = ph; r.gc = gc; r.chk = chk;
    r.v = v; r.b = b; r.po = po; r.dp = dp;
    return r;
  endfunction

  // Tap vector with the first p taps equal to s0 and the rest inverted.
  function automatic logic [31:0] mk_taps(bit s0, int p);
    logic [31:0] m;
    m = (p == 0) ? 32'hFFFF_FFFF : ((32'd1 << p) - 32'd1);
    return s0 ? m : ~m;
  endfunction

  task automatic check(input vec_t e, input string tag);
    n_vec++;
    if (valid !== e.v) begin
      n_miss++;
      $display("FAIL %s[%0d] valid: got %0b want %0b", tag, e.id, valid, e.v);
    end
    if (bubble_err !== e.b) begin
      n_miss++;
      $display("FAIL %s[%0d] bubble_err: got %0b want %0b", tag, e.id, bubble_err, e.b);
    end
    if (phase_out !== e.po) begin
      n_miss++;
      $display("FAIL %s[%0d] phase_out: got %0d want %0d", tag, e.id, phase_out, e.po);
    end
    if (dphase !== e.dp) begin
      n_miss++;
      $display("FAIL %s[%0d] dphase: got %0d want %0d", tag, e.id, dphase, e.dp);
    end
    if (valid === 1'b1 && bubble_err === 1'b1) begin
      n_miss++;
      $display("FAIL %s[%0d] strobes: got valid=1 bubble_err=1 want at most one", tag, e.id);
    end
  endtask

  // Drive one sample; the result of a sample is visible two negedges later.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk) check(e, "vec");
    end
    en           = v.en;
    osc_phases   = v.ph;
    osc_cnt_gray = v.gc;
    sb.push_back(v);
  endtask

  initial begin
    vec_t tbl[19];
    vec_t z;
    int   prev;
    int   phv;

    tbl[0]  = mkv(100, 1, 32'h0000_00FF, 8'h03, 1, 0, 0, 14'd136,   14'd0);
    tbl[1]  = mkv(101, 1, 32'hFFFF_FF00, 8'h02, 1, 1, 0, 14'd232,   14'd96);
    tbl[2]  = mkv(102, 1, 32'hF000_0000, 8'h80, 1, 1, 0, 14'd16380, 14'd16148);
    tbl[3]  = mkv(103, 1, 32'h0000_000F, 8'h00, 1, 1, 0, 14'd4,     14'd8);
    tbl[4]  = mkv(104, 1, 32'h0000_F0F0, 8'h01, 1, 0, 1, 14'd4,     14'd8);
    tbl[5]  = mkv(105, 1, 32'h0000_03FF, 8'h01, 1, 1, 0, 14'd74,    14'd70);
    tbl[6]  = mkv(106, 1, 32'hFFFF_FFFF, 8'h03, 1, 1, 0, 14'd128,   14'd54);
    tbl[7]  = mkv(107, 1, 32'h0000_0000, 8'h03, 1, 1, 0, 14'd160,   14'd32);
    tbl[8]  = mkv(108, 1, 32'h0000_FFFF, 8'h02, 1, 0, 0, 14'd160,   14'd32);
    tbl[9]  = mkv(109, 0, 32'h0000_0000, 8'h00, 1, 0, 0, 14'd160,   14'd32);
    tbl[10] = mkv(110, 1, 32'h0000_00FF, 8'h03, 1, 0, 0, 14'd136,   14'd32);
    tbl[11] = mkv(111, 1, 32'hFFFF_FF00, 8'h02, 1, 1, 0, 14'd232,   14'd96);
    tbl[12] = mkv(112, 1, 32'h0000_FFFF, 8'h02, 1, 0, 0, 14'd232,   14'd96);
    tbl[13] = mkv(113, 0, 32'h0000_0000, 8'h00, 1, 0, 0, 14'd232,   14'd96);
    tbl[14] = mkv(114, 1, 32'h00FF_00FF, 8'h00, 1, 0, 1, 14'd232,   14'd96);
    tbl[15] = mkv(115, 1, 32'h0000_FFFF, 8'h02, 1, 0, 0, 14'd208,   14'd96);
    tbl[16] = mkv(116, 1, 32'h0000_0001, 8'h02, 1, 1, 0, 14'd193,   14'd16369);
    tbl[17] = mkv(117, 1, 32'h8000_0001, 8'h02, 1, 0, 1, 14'd193,   14'd16369);
    tbl[18] = mkv(118, 1, 32'hFFFF_FFFE, 8'h02, 1, 1, 0, 14'd225,   14'd32);

    z = mkv(0, 0, '0, '0, 1, 0, 0, 14'd0, 14'd0);

    #1;
    check(z, "rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(mkv(i, 0, '0, '0, 1, 0, 0, 14'd0, 14'd0));

    for (int i = 0; i < 19; i++) step(tbl[i]);

    // Walk the edge across every tap for both polarities at count 5 (Gray 7).
    prev = 225;
    for (int f = 0; f < 64; f++) begin
      phv = 320 + f;
      step(mkv(200 + f, 1, mk_taps(f < 32, f % 32), 8'h07, 1, 1, 0,
               14'(phv), 14'(phv - prev)));
      prev = phv;
    end
    step(mkv(264, 1, 32'hFFFF_FFFF, 8'h07, 0, 0, 0, 14'd0, 14'd0));
    step(mkv(265, 1, 32'hFFFF_FFFF, 8'h07, 0, 0, 0, 14'd0, 14'd0));
    sb.delete();

    // Asynchronous reset in RUN with the clock held low.
    clk_run = 1'b0;
    en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    z.id = 1;
    check(z, "rst_mid");
    #20;
    rst_n = 1'b1;
    #2;
    clk_run = 1'b1;

    for (int i = 0; i < 10; i++) step(mkv(20 + i, 0, '0, '0, 1, 0, 0, 14'd0, 14'd0));
    step(mkv(300, 1, 32'h0000_00FF, 8'h03, 1, 0, 0, 14'd136, 14'd0));
    step(mkv(301, 1, 32'hFFFF_FF00, 8'h02, 1, 1, 0, 14'd232, 14'd96));
    step(mkv(302, 1, 32'hFFFF_FF00, 8'h02, 0, 0, 0, 14'd0, 14'd0));
    step(mkv(303, 1, 32'hFFFF_FF00, 8'h02, 0, 0, 0, 14'd0, 14'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
